// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter.
//   clog2       : ceiling log2 used to size the requester ID and the step counter
//   state_t     : two-state controller encoding (IDLE, BUSY)
//   *_DEFAULT   : default operand widths and requester count
package mult_arb_pkg;

    localparam int N_DEFAULT = 4;
    localparam int M_DEFAULT = 4;
    localparam int R_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_arbiter_engine.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
//   i_clk, i_rst : clock, synchronous active-high reset (clears all registers)
//   load         : capture op1/op2 and clear the accumulator
//   op1 [N-1:0]  : multiplicand
//   op2 [M-1:0]  : multiplier
//   step         : perform one shift-add step
//   acc [N+M-1:0]: running product, exact after M steps
module mult_engine
    import mult_arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load,
    input  logic [N-1:0]     op1,
    input  logic [M-1:0]     op2,
    input  logic             step,
    output logic [N+M-1:0]   acc
);

    // Multiplicand is kept at full product width so it can shift left
    // M times without losing bits that still contribute to the sum.
    logic [N+M-1:0] mcand;
    logic [M-1:0]   mplier;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= {{M{1'b0}}, op1};
            mplier <= op2;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter in front of a single shared iterative multiplier.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_req_valid    : per-requester request valid [R]
//   i_req_mult1    : packed operand 1, requester k at [k*N +: N]
//   i_req_mult2    : packed operand 2, requester k at [k*M +: M]
//   o_req_ready    : one-hot grant, only in IDLE and out of reset
//   o_result       : last completed product (N+M bits), held until next completion
//   o_result_valid : one-cycle pulse qualifying o_result / o_result_id
//   o_result_id    : requester that owns o_result
//   o_busy         : operation in flight
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT,
    parameter int R = R_DEFAULT,
    localparam int ID_W = clog2(R)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [R-1:0]       i_req_valid,
    input  logic [R*N-1:0]     i_req_mult1,
    input  logic [R*M-1:0]     i_req_mult2,
    output logic [R-1:0]       o_req_ready,
    output logic [N+M-1:0]     o_result,
    output logic               o_result_valid,
    output logic [ID_W-1:0]    o_result_id,
    output logic               o_busy
);

    localparam int CNT_W = clog2(M + 1);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   rr_idx;
    logic [ID_W-1:0]   cur_id;
    logic [R-1:0]      ready;
    logic              accept;
    logic [CNT_W-1:0]  cnt;
    logic              eng_step;
    logic [N-1:0]      sel_mult1;
    logic [M-1:0]      sel_mult2;
    logic [N+M-1:0]    eng_acc;

    // Round-robin search starts one past the last grant and wraps, so the
    // requester just served has the lowest priority on the next pick.
    always_comb begin
        ready    = '0;
        grant_id = '0;
        accept   = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= R; i++) begin
            rr_idx = ID_W'((int'(last_grant) + i) % R);
            if (!accept && i_req_valid[rr_idx]) begin
                ready[rr_idx] = 1'b1;
                grant_id      = rr_idx;
                accept        = 1'b1;
            end
        end
        if (state != ST_IDLE || i_rst) begin
            ready  = '0;
            accept = 1'b0;
        end
    end

    assign sel_mult1 = i_req_mult1[int'(grant_id)*N +: N];
    assign sel_mult2 = i_req_mult2[int'(grant_id)*M +: M];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BUSY steps the engine while cnt runs 0..M-1; the cycle with cnt == M
    // publishes the product and frees the multiplier.
    always_comb begin
        state_nxt = state;
        eng_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(M)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    eng_step = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt            <= '0;
            last_grant     <= ID_W'(R - 1);
            cur_id         <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_result_id    <= '0;
        end else begin
            o_result_valid <= 1'b0;
            if (accept) begin
                cur_id     <= grant_id;
                last_grant <= grant_id;
                cnt        <= '0;
            end else if (state == ST_BUSY) begin
                if (cnt == CNT_W'(M)) begin
                    o_result       <= eng_acc;
                    o_result_id    <= cur_id;
                    o_result_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    mult_engine #(
        .N (N),
        .M (M)
    ) u_engine (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .load  (accept),
        .op1   (sel_mult1),
        .op2   (sel_mult2),
        .step  (eng_step),
        .acc   (eng_acc)
    );

    assign o_req_ready = ready;
    assign o_busy      = (state == ST_BUSY);

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N, default 4, width of operand 1 (unsigned).
REQ-002 Parameter M, default 4, width of operand 2 (unsigned); also the iteration count.
REQ-003 Parameter R, default 4, number of requesters (R >= 2); ID_W = clog2(R).
REQ-004 i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_req_valid  input  R  per-requester request valid.
REQ-007 i_req_mult1  input  R*N  packed operand 1; requester k occupies bits [k*N +: N].
REQ-008 i_req_mult2  input  R*M  packed operand 2; requester k occupies bits [k*M +: M].
REQ-009 o_req_ready  output  R  one-hot grant/ready; requester k is accepted when i_req_valid[k] & o_req_ready[k].
REQ-010 o_result  output  N+M  product of the last completed operation.
REQ-011 o_result_valid  output  1  single-cycle pulse qualifying o_result and o_result_id.
REQ-012 o_result_id  output  ID_W  index of the requester that owns o_result.
REQ-013 o_busy  output  1  high while an operation is in flight (state BUSY).

Function
REQ-014 The block SHALL use a two-state FSM: IDLE and BUSY.
REQ-015 In IDLE, o_req_ready SHALL combinationally select exactly one valid requester, round-robin from index (last_grant+1) mod R upward with wrap. o_req_ready SHALL be all-zero when no request is valid or when in BUSY.
REQ-016 On the acceptance edge A, the block SHALL latch the granted operands and ID, update last_grant, load the engine, clear the counter, and enter BUSY.
REQ-017 BUSY SHALL perform one shift-add step per cycle for M cycles.
  - A 0..M counter is used.
  - When the counter equals M: o_result <= exact N+M-bit unsigned product; o_result_valid <= 1 for one cycle; state <= IDLE.
REQ-018 o_result_valid SHALL be high exactly in the cycle after edge A+M+1. o_result and o_result_id SHALL hold their value until the next completion.
REQ-019 A new acceptance SHALL be possible in the same cycle that o_result_valid is high. Minimum spacing between acceptances is M+2 cycles.
REQ-020 Requesters not granted SHALL hold valid and operands stable. A request withdrawn before grant SHALL have no effect.
REQ-021 Changes to i_req_* while in BUSY SHALL NOT affect the in-flight result.
REQ-022 The product SHALL be exact with no truncation. Zero operands SHALL yield 0 with normal latency and a normal valid pulse.
REQ-023 There SHALL be no result backpressure; every accepted request SHALL produce exactly one o_result_valid pulse.

Reset
REQ-024 While i_rst is high at an edge, the block SHALL go to IDLE and clear all of the following:
  - counter, engine registers, o_result (0), o_result_valid (0), o_result_id (0).
  - last_grant SHALL be set to R-1, so requester 0 has first priority.
REQ-025 A reset during BUSY SHALL discard the in-flight operation with no valid pulse. o_req_ready SHALL be all-zero while i_rst is high.

Structure
REQ-026 A shared package mult_arb_pkg SHALL hold the clog2 function, the IDLE/BUSY state encoding, and the default N, M and R constants.
REQ-027 The iterative shift-add datapath SHALL be one sub-module, mult_engine, with ports: load, operands, step enable, and an N+M-bit accumulator out. Arbitration and FSM SHALL stay in mult_arbiter.

Verification
REQ-028 Single request, N=M=4, R=4: req0 valid with 13, 3 -> ready[0] high at edge A; o_result=39, id=0, valid pulse after edge A+5; o_busy high for 5 cycles.
REQ-029 All four requests valid at once with operands (1,1), (2,3), (15,15), (0,9) -> grants in order 0,1,2,3; results 1, 6, 225, 0; valid pulses 6 cycles apart.
REQ-030 Fairness: req0 and req2 held valid continuously -> grant order alternates 0,2,0,2,...; no two consecutive grants to the same requester.
REQ-031 Max operands: 15 x 15 on req3 -> o_result=225 (8'hE1); no truncation.
REQ-032 Reset mid-op: assert i_rst at edge A+2 of a 7 x 7 operation -> no valid pulse; o_result=0; next request from req1 after reset wins over req3.
REQ-033 Back-to-back: req1 re-asserts valid during the o_result_valid cycle -> accepted in that same cycle; the following result appears M+2 cycles after the previous one.
